// File: rtl/wrr_cfg_sequencer_if.sv
// Host register-bus, bulk-init and calculator CPU-port signals of wrr_cfg_sequencer.
// master: the sequencer itself; slave: the host decoder and rank calculator facing it.
interface wrr_cfg_sequencer_if #(
  parameter int CPU_INDEX_WIDTH = 8,
  parameter int CPU_WRITE_WIDTH = 8,
  parameter int CPU_OUT_WIDTH   = 27
);
  logic                       host_req_valid;
  logic                       host_req_ready;
  logic                       host_req_write;
  logic [CPU_INDEX_WIDTH-1:0] host_req_index;
  logic [CPU_WRITE_WIDTH-1:0] host_req_wdata;
  logic                       host_rsp_valid;
  logic [CPU_INDEX_WIDTH-1:0] host_rsp_index;
  logic [CPU_OUT_WIDTH-1:0]   host_rsp_data;
  logic                       host_rsp_error;

  logic                       init_start;
  logic                       init_busy;
  logic                       init_done;
  logic                       init_error;

  logic                       cpu_valid;
  logic                       cpu_write_sig;
  logic                       cpu_read_sig;
  logic [CPU_INDEX_WIDTH-1:0] cpu_index;
  logic [CPU_WRITE_WIDTH-1:0] cpu_config_write;
  logic                       cpu_rsp_valid;
  logic [CPU_INDEX_WIDTH-1:0] cpu_rsp_index;
  logic [CPU_OUT_WIDTH-1:0]   cpu_rsp_val;

  modport master (
    input  host_req_valid, host_req_write, host_req_index, host_req_wdata,
    input  init_start,
    input  cpu_rsp_valid, cpu_rsp_index, cpu_rsp_val,
    output host_req_ready, host_rsp_valid, host_rsp_index, host_rsp_data, host_rsp_error,
    output init_busy, init_done, init_error,
    output cpu_valid, cpu_write_sig, cpu_read_sig, cpu_index, cpu_config_write
  );

  modport slave (
    output host_req_valid, host_req_write, host_req_index, host_req_wdata,
    output init_start,
    output cpu_rsp_valid, cpu_rsp_index, cpu_rsp_val,
    input  host_req_ready, host_rsp_valid, host_rsp_index, host_rsp_data, host_rsp_error,
    input  init_busy, init_done, init_error,
    input  cpu_valid, cpu_write_sig, cpu_read_sig, cpu_index, cpu_config_write
  );
endinterface

// File: rtl/wrr_cfg_sequencer.sv
// Serialises host register requests and a bulk weight-init sweep onto the rank calculator's CPU port.
// Optional macro WRR_CFG_READBACK_VERIFY_EN: during init, compare returned config_weight with DEFAULT_WEIGHT.
module wrr_cfg_sequencer #(
  parameter int CPU_INDEX_WIDTH = 8,
  parameter int CPU_WRITE_WIDTH = 8,
  parameter int CPU_OUT_WIDTH   = 27,
  parameter int ID_LENGHT       = 160,
  parameter int DEFAULT_WEIGHT  = 1,
  parameter int RSP_TIMEOUT     = 15
) (
  input logic                clk_cp,
  input logic                rst,
  wrr_cfg_sequencer_if.master bus
);

  localparam int IW = CPU_INDEX_WIDTH;
  localparam int WW = CPU_WRITE_WIDTH;
  localparam int OW = CPU_OUT_WIDTH;

  localparam logic [IW:0]   ID_LIMIT = (IW+1)'(ID_LENGHT);
  localparam logic [IW-1:0] LAST_IDX = IW'(ID_LENGHT - 1);
  localparam logic [WW-1:0] DEF_W    = WW'(DEFAULT_WEIGHT);
  localparam logic [7:0]    TO_LAST  = 8'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, RESP, INIT_ISSUE, INIT_WAIT, INIT_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [7:0]    cnt_reg, cnt_next;

  logic          cpu_valid_reg, cpu_valid_next;
  logic          cpu_write_reg, cpu_write_next;
  logic          cpu_read_reg, cpu_read_next;
  logic [IW-1:0] cpu_index_reg, cpu_index_next;
  logic [WW-1:0] cpu_cfg_reg, cpu_cfg_next;

  logic          rsp_valid_reg, rsp_valid_next;
  logic [IW-1:0] rsp_index_reg, rsp_index_next;
  logic [OW-1:0] rsp_data_reg, rsp_data_next;
  logic          rsp_error_reg, rsp_error_next;

  logic          init_busy_reg, init_busy_next;
  logic          init_done_reg, init_done_next;
  logic          init_error_reg, init_error_next;

  logic          rsp_match;
  logic          timeout;

  // Only the response for the outstanding index counts; stray ones are dropped.
  assign rsp_match = bus.cpu_rsp_valid && (bus.cpu_rsp_index == idx_reg);
  assign timeout   = (cnt_reg == TO_LAST);

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    cpu_valid_next  = 1'b0;
    cpu_write_next  = 1'b0;
    cpu_read_next   = 1'b0;
    cpu_index_next  = '0;
    cpu_cfg_next    = '0;
    rsp_valid_next  = 1'b0;
    rsp_index_next  = '0;
    rsp_data_next   = '0;
    rsp_error_next  = 1'b0;
    init_done_next  = 1'b0;
    init_error_next = init_error_reg;

    // Outputs are registered, so the issue/response beats are decided on the transition into their state.
    case (state_reg)
      IDLE: begin
        if (bus.init_start) begin
          state_next      = INIT_ISSUE;
          idx_next        = '0;
          init_error_next = 1'b0;
          cpu_valid_next  = 1'b1;
          cpu_write_next  = 1'b1;
          cpu_index_next  = '0;
          cpu_cfg_next    = DEF_W;
        end else if (bus.host_req_valid) begin
          idx_next = bus.host_req_index;
          if ({1'b0, bus.host_req_index} >= ID_LIMIT) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_index_next = bus.host_req_index;
            rsp_error_next = 1'b1;
          end else begin
            state_next     = ISSUE;
            cpu_valid_next = 1'b1;
            cpu_write_next = bus.host_req_write;
            cpu_read_next  = !bus.host_req_write;
            cpu_index_next = bus.host_req_index;
            cpu_cfg_next   = bus.host_req_write ? bus.host_req_wdata : '0;
          end
        end
      end

      ISSUE: begin
        state_next = WAIT;
        cnt_next   = '0;
      end

      WAIT: begin
        if (rsp_match) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_index_next = idx_reg;
          rsp_data_next  = bus.cpu_rsp_val;
        end else if (timeout) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_index_next = idx_reg;
          rsp_error_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      INIT_ISSUE: begin
        state_next = INIT_WAIT;
        cnt_next   = '0;
      end

      INIT_WAIT: begin
        if (rsp_match || timeout) begin
          if (!rsp_match) begin
            init_error_next = 1'b1;
          end
`ifdef WRR_CFG_READBACK_VERIFY_EN
          if (rsp_match && (bus.cpu_rsp_val[2*WW-1:WW] != DEF_W)) begin
            init_error_next = 1'b1;
          end
`endif
          if (idx_reg == LAST_IDX) begin
            state_next     = INIT_DONE;
            init_done_next = 1'b1;
          end else begin
            state_next     = INIT_ISSUE;
            idx_next       = idx_reg + IW'(1);
            cpu_valid_next = 1'b1;
            cpu_write_next = 1'b1;
            cpu_index_next = idx_reg + IW'(1);
            cpu_cfg_next   = DEF_W;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      INIT_DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    init_busy_next = (state_next == INIT_ISSUE) || (state_next == INIT_WAIT) ||
                     (state_next == INIT_DONE);
  end

  always_ff @(posedge clk_cp or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      cpu_valid_reg  <= 1'b0;
      cpu_write_reg  <= 1'b0;
      cpu_read_reg   <= 1'b0;
      cpu_index_reg  <= '0;
      cpu_cfg_reg    <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_index_reg  <= '0;
      rsp_data_reg   <= '0;
      rsp_error_reg  <= 1'b0;
      init_busy_reg  <= 1'b0;
      init_done_reg  <= 1'b0;
      init_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      cpu_valid_reg  <= cpu_valid_next;
      cpu_write_reg  <= cpu_write_next;
      cpu_read_reg   <= cpu_read_next;
      cpu_index_reg  <= cpu_index_next;
      cpu_cfg_reg    <= cpu_cfg_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_index_reg  <= rsp_index_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_error_reg  <= rsp_error_next;
      init_busy_reg  <= init_busy_next;
      init_done_reg  <= init_done_next;
      init_error_reg <= init_error_next;
    end
  end

  // Ready is the one combinational output; init_start in the same cycle takes priority.
  assign bus.host_req_ready   = (state_reg == IDLE) && !bus.init_start && !rst;
  assign bus.host_rsp_valid   = rsp_valid_reg;
  assign bus.host_rsp_index   = rsp_index_reg;
  assign bus.host_rsp_data    = rsp_data_reg;
  assign bus.host_rsp_error   = rsp_error_reg;
  assign bus.init_busy        = init_busy_reg;
  assign bus.init_done        = init_done_reg;
  assign bus.init_error       = init_error_reg;
  assign bus.cpu_valid        = cpu_valid_reg;
  assign bus.cpu_write_sig    = cpu_write_reg;
  assign bus.cpu_read_sig     = cpu_read_reg;
  assign bus.cpu_index        = cpu_index_reg;
  assign bus.cpu_config_write = cpu_cfg_reg;

endmodule

// File: tb/tb_wrr_cfg_sequencer.sv
// Directed bench for wrr_cfg_sequencer: cycle-scheduled expectation model plus a behavioural calculator responder.
module tb_wrr_cfg_sequencer;
  localparam int IW   = 8;
  localparam int WW   = 8;
  localparam int OW   = 27;
  localparam int IDL  = 160;
  localparam int DEFW = 1;
  localparam int TO   = 15;

  logic clk_cp = 1'b0;
  logic rst    = 1'b1;
  always #5 clk_cp = ~clk_cp;

  wrr_cfg_sequencer_if #(.CPU_INDEX_WIDTH(IW), .CPU_WRITE_WIDTH(WW), .CPU_OUT_WIDTH(OW)) bus ();

  wrr_cfg_sequencer #(
    .CPU_INDEX_WIDTH(IW), .CPU_WRITE_WIDTH(WW), .CPU_OUT_WIDTH(OW),
    .ID_LENGHT(IDL), .DEFAULT_WEIGHT(DEFW), .RSP_TIMEOUT(TO)
  ) dut (
    .clk_cp(clk_cp),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       w;
    logic [7:0] idx;
    logic [7:0] cfg;
  } cpu_exp_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [26:0] data;
    logic        err;
  } rsp_exp_t;

  typedef enum int {M_NORMAL, M_SILENT, M_DECOY, M_BAD9} mode_t;

  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  bit       chk_en = 1'b0;
  mode_t    mode = M_NORMAL;
  cpu_exp_t exp_cpu[int];
  rsp_exp_t exp_rsp[int];
  logic     ierr_change[int];
  int       done_cyc = -1;
  int       busy_from = 1;
  int       busy_to = 0;
  int       last_done = -1;
  logic     exp_ierr = 1'b0;
  logic [7:0] model_cfg[256];
  logic [7:0] resp_mem[256];

  always @(posedge clk_cp) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the scheduled expectations.
  initial begin
    cpu_exp_t ce;
    rsp_exp_t re;
    forever begin
      @(negedge clk_cp);
      if (bus.init_done) last_done = cyc;
      if (chk_en) begin
        if (exp_cpu.exists(cyc)) begin
          ce = exp_cpu[cyc];
          chk("cpu_valid", 32'(bus.cpu_valid), 32'(1));
          chk("cpu_write_sig", 32'(bus.cpu_write_sig), 32'(ce.w));
          chk("cpu_read_sig", 32'(bus.cpu_read_sig), 32'(!ce.w));
          chk("cpu_index", 32'(bus.cpu_index), 32'(ce.idx));
          chk("cpu_config_write", 32'(bus.cpu_config_write), 32'(ce.cfg));
        end else begin
          chk("cpu_quiet", 32'({bus.cpu_valid, bus.cpu_write_sig, bus.cpu_read_sig,
                                bus.cpu_index, bus.cpu_config_write}), 32'(0));
        end
        if (exp_rsp.exists(cyc)) begin
          re = exp_rsp[cyc];
          chk("host_rsp_valid", 32'(bus.host_rsp_valid), 32'(1));
          chk("host_rsp_index", 32'(bus.host_rsp_index), 32'(re.idx));
          chk("host_rsp_data", 32'(bus.host_rsp_data), 32'(re.data));
          chk("host_rsp_error", 32'(bus.host_rsp_error), 32'(re.err));
        end else begin
          chk("host_rsp_quiet", 32'(bus.host_rsp_valid), 32'(0));
        end
        chk("init_done", 32'(bus.init_done), 32'(cyc == done_cyc));
        chk("init_busy", 32'(bus.init_busy), 32'(cyc >= busy_from && cyc <= busy_to));
        if (ierr_change.exists(cyc)) exp_ierr = ierr_change[cyc];
        chk("init_error", 32'(bus.init_error), 32'(exp_ierr));
      end
    end
  end

  // Calculator model: answers one cycle after cpu_valid with {round 0, stored weight, index}.
  initial begin
    logic        cv, cw, carry_v;
    logic [7:0]  ci, cc, cfg, carry_i;
    logic [26:0] val, carry_d;
    carry_v = 1'b0;
    carry_i = '0;
    carry_d = '0;
    bus.cpu_rsp_valid = 1'b0;
    bus.cpu_rsp_index = '0;
    bus.cpu_rsp_val   = '0;
    forever begin
      @(negedge clk_cp);
      cv = bus.cpu_valid;
      cw = bus.cpu_write_sig;
      ci = bus.cpu_index;
      cc = bus.cpu_config_write;
      @(posedge clk_cp);
      #1;
      bus.cpu_rsp_valid = 1'b0;
      bus.cpu_rsp_index = '0;
      bus.cpu_rsp_val   = '0;
      if (carry_v) begin
        bus.cpu_rsp_valid = 1'b1;
        bus.cpu_rsp_index = carry_i;
        bus.cpu_rsp_val   = carry_d;
        carry_v = 1'b0;
      end
      if (cv && mode != M_SILENT) begin
        if (cw) resp_mem[ci] = cc;
        cfg = (mode == M_BAD9 && ci == 8'd9) ? 8'd2 : resp_mem[ci];
        val = {11'd0, cfg, ci};
        bus.cpu_rsp_valid = 1'b1;
        bus.cpu_rsp_val   = val;
        if (mode == M_DECOY) begin
          bus.cpu_rsp_index = ci + 8'd1;
          carry_v = 1'b1;
          carry_i = ci;
          carry_d = val;
        end else begin
          bus.cpu_rsp_index = ci;
        end
      end
    end
  end

  task automatic at_cycle(input int c);
    @(negedge clk_cp);
    while (cyc < c) @(negedge clk_cp);
  endtask

  task automatic host_txn(input string tag, input logic w, input logic [7:0] idx,
                          input logic [7:0] wd, output int n);
    bit       acc;
    cpu_exp_t c;
    rsp_exp_t r;
    acc = 1'b0;
    n = -1;
    @(posedge clk_cp);
    #1;
    bus.host_req_valid = 1'b1;
    bus.host_req_write = w;
    bus.host_req_index = idx;
    bus.host_req_wdata = wd;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk_cp);
      if (bus.host_req_ready) begin
        acc = 1'b1;
        n = cyc;
      end
      @(posedge clk_cp);
      #1;
    end
    bus.host_req_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_%s: got no ready within 2000 cycles, required acceptance", tag);
    end else begin
      // Latencies from the accept cycle: out-of-range +1, match +3, decoy first +4, silent +2+timeout.
      r.idx = idx;
      if (int'(idx) >= IDL) begin
        r.data = '0;
        r.err  = 1'b1;
        exp_rsp[n + 1] = r;
      end else begin
        c.w   = w;
        c.idx = idx;
        c.cfg = w ? wd : 8'd0;
        exp_cpu[n + 1] = c;
        if (mode == M_SILENT) begin
          r.data = '0;
          r.err  = 1'b1;
          exp_rsp[n + 2 + TO] = r;
        end else begin
          if (w) model_cfg[idx] = wd;
          r.data = {11'd0, model_cfg[idx], idx};
          r.err  = 1'b0;
          exp_rsp[n + ((mode == M_DECOY) ? 4 : 3)] = r;
        end
      end
      $display("txn %s %s idx=%0d wdata=%0h accepted at cycle %0d", tag, w ? "wr" : "rd", idx, wd, n);
    end
  endtask

  // Starts init while also presenting a host read of index 7 in the same cycle.
  task automatic init_run(input mode_t m, output int s);
    cpu_exp_t c;
    mode = m;
    @(posedge clk_cp);
    #1;
    bus.init_start     = 1'b1;
    bus.host_req_valid = 1'b1;
    bus.host_req_write = 1'b0;
    bus.host_req_index = 8'd7;
    bus.host_req_wdata = 8'd0;
    @(negedge clk_cp);
    s = cyc;
    chk("ready_during_init_start", 32'(bus.host_req_ready), 32'(0));
    for (int k = 0; k < IDL; k++) begin
      c.w   = 1'b1;
      c.idx = 8'(k);
      c.cfg = 8'(DEFW);
      exp_cpu[s + 1 + 2 * k] = c;
      model_cfg[k] = 8'(DEFW);
    end
    busy_from = s + 1;
    busy_to   = s + 2 * IDL + 1;
    done_cyc  = s + 2 * IDL + 1;
    ierr_change[s + 1] = 1'b0;
`ifdef WRR_CFG_READBACK_VERIFY_EN
    if (m == M_BAD9) ierr_change[s + 2 * 9 + 3] = 1'b1;
`endif
    @(posedge clk_cp);
    #1;
    bus.init_start = 1'b0;
    $display("txn init mode=%0d started at cycle %0d", m, s);
  endtask

  initial begin
    int n, n_prev, s;
    logic exp_bad9_err;
    bus.host_req_valid = 1'b0;
    bus.host_req_write = 1'b0;
    bus.host_req_index = '0;
    bus.host_req_wdata = '0;
    bus.init_start     = 1'b0;
    for (int i = 0; i < 256; i++) begin
      model_cfg[i] = '0;
      resp_mem[i]  = '0;
    end
    model_cfg[5] = 8'h03;
    resp_mem[5]  = 8'h03;

    rst = 1'b1;
    repeat (3) @(negedge clk_cp);
    chk("reset_ready", 32'(bus.host_req_ready), 32'(0));
    chk("reset_cpu", 32'({bus.cpu_valid, bus.cpu_write_sig, bus.cpu_read_sig,
                          bus.cpu_index, bus.cpu_config_write}), 32'(0));
    chk("reset_host", 32'({bus.host_rsp_valid, bus.host_rsp_index, bus.host_rsp_error,
                           bus.init_busy, bus.init_done, bus.init_error}), 32'(0));
    chk("reset_rsp_data", 32'(bus.host_rsp_data), 32'(0));
    @(posedge clk_cp);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk_cp);
    chk("ready_after_reset", 32'(bus.host_req_ready), 32'(1));

    mode = M_NORMAL;
    host_txn("rd5", 1'b0, 8'd5, 8'd0, n);
    at_cycle(n + 3);
    chk("rd5_valid", 32'(bus.host_rsp_valid), 32'(1));
    chk("rd5_index", 32'(bus.host_rsp_index), 32'(5));
    chk("rd5_data", 32'(bus.host_rsp_data), 32'h0000305);
    chk("rd5_error", 32'(bus.host_rsp_error), 32'(0));

    host_txn("wr7", 1'b1, 8'd7, 8'h04, n);
    at_cycle(n + 1);
    chk("wr7_cpu_valid", 32'(bus.cpu_valid), 32'(1));
    chk("wr7_cpu_write", 32'(bus.cpu_write_sig), 32'(1));
    chk("wr7_cpu_index", 32'(bus.cpu_index), 32'(7));
    chk("wr7_cpu_cfg", 32'(bus.cpu_config_write), 32'(4));
    at_cycle(n + 2);
    chk("wr7_single_beat", 32'(bus.cpu_valid), 32'(0));
    at_cycle(n + 3);
    chk("wr7_rsp_data", 32'(bus.host_rsp_data), 32'h0000407);
    chk("wr7_rsp_error", 32'(bus.host_rsp_error), 32'(0));

    host_txn("rd160", 1'b0, 8'd160, 8'd0, n);
    at_cycle(n + 1);
    chk("rd160_valid", 32'(bus.host_rsp_valid), 32'(1));
    chk("rd160_error", 32'(bus.host_rsp_error), 32'(1));
    chk("rd160_data", 32'(bus.host_rsp_data), 32'(0));
    chk("rd160_no_issue", 32'(bus.cpu_valid), 32'(0));

    mode = M_SILENT;
    host_txn("rd3_silent", 1'b0, 8'd3, 8'd0, n);
    at_cycle(n + 16);
    chk("timeout_not_early", 32'(bus.host_rsp_valid), 32'(0));
    at_cycle(n + 17);
    chk("timeout_valid", 32'(bus.host_rsp_valid), 32'(1));
    chk("timeout_error", 32'(bus.host_rsp_error), 32'(1));
    chk("timeout_data", 32'(bus.host_rsp_data), 32'(0));
    n_prev = n;

    mode = M_NORMAL;
    host_txn("rd5_after_timeout", 1'b0, 8'd5, 8'd0, n);
    chk("accept_after_timeout", 32'(n), 32'(n_prev + 18));
    at_cycle(n + 3);
    chk("rd5_again_data", 32'(bus.host_rsp_data), 32'h0000305);

    mode = M_DECOY;
    host_txn("rd6_decoy", 1'b0, 8'd6, 8'd0, n);
    at_cycle(n + 3);
    chk("decoy_ignored", 32'(bus.host_rsp_valid), 32'(0));
    at_cycle(n + 4);
    chk("decoy_valid", 32'(bus.host_rsp_valid), 32'(1));
    chk("decoy_data", 32'(bus.host_rsp_data), 32'h0000006);

    init_run(M_NORMAL, s);
    host_txn("rd7_held_by_init", 1'b0, 8'd7, 8'd0, n);
    chk("init_done_cycle", 32'(last_done), 32'(s + 321));
    chk("held_accept_cycle", 32'(n), 32'(s + 322));
    at_cycle(n + 3);
    chk("rd7_after_init_data", 32'(bus.host_rsp_data), 32'h0000107);
    chk("init_error_clean", 32'(bus.init_error), 32'(0));

    init_run(M_BAD9, s);
    host_txn("rd7_after_bad9", 1'b0, 8'd7, 8'd0, n);
    at_cycle(n + 3);
`ifdef WRR_CFG_READBACK_VERIFY_EN
    exp_bad9_err = 1'b1;
`else
    exp_bad9_err = 1'b0;
`endif
    chk("bad9_init_error", 32'(bus.init_error), 32'(exp_bad9_err));
    chk("bad9_init_done_cycle", 32'(last_done), 32'(s + 321));

    repeat (5) @(negedge clk_cp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1);
  end

endmodule
